uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  bit clock; one serial bit per rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  P_DATA valid request.
REQ-006 SHALL have port PAR_EN  input  1  insert parity bit (present only with UART_TX_PARITY_EN).
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity (present only with UART_TX_PARITY_EN).
REQ-008 SHALL have port TX_OUT  output  1  serial line; idle high.
REQ-009 SHALL have port BUSY  output  1  frame in progress.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a frame when DATA_VALID=1 in IDLE, or in STOP (back-to-back); P_DATA, PAR_EN and PAR_TYP are latched on that edge.
REQ-012 SHALL ignore DATA_VALID in START, DATA and PARITY; no request is queued.
REQ-013 SHALL drive TX_OUT=0 for one cycle in START, starting the cycle after acceptance.
REQ-014 SHALL shift out the latched data LSB first, one bit per cycle, for DATA_WIDTH cycles; a bit counter of $clog2(DATA_WIDTH) bits wraps to 0 on leaving DATA.
REQ-015 SHALL, in PARITY, drive XOR of latched data (even) or its inverse (odd), for one cycle.
REQ-016 SHALL skip PARITY (DATA -> STOP) when latched PAR_EN=0.
REQ-017 SHALL drive TX_OUT=1 for one cycle in STOP, then go to START if DATA_VALID=1, else to IDLE.
REQ-018 SHALL drive TX_OUT=1 in IDLE.
REQ-019 SHALL hold BUSY=1 from START through STOP, including across back-to-back frames, and BUSY=0 only in IDLE.
REQ-020 SHALL register TX_OUT and BUSY; there is no combinational path from inputs to outputs.
REQ-021 SHALL produce frames of 2+DATA_WIDTH cycles without parity and 3+DATA_WIDTH cycles with parity.
REQ-022 SHALL ignore changes on P_DATA, PAR_EN and PAR_TYP after acceptance until the frame completes.

Reset
REQ-023 SHALL, on RST=0, asynchronously force state=IDLE, TX_OUT=1, BUSY=0, bit counter=0 and data register=0.
REQ-024 SHALL abort a frame on reset mid-frame without emitting further bits; the first frame after reset release requires a new DATA_VALID.

Configuration
REQ-025 SHALL use macro UART_TX_PARITY_EN to compile the parity feature in.
REQ-026 SHALL, with the macro defined, provide PAR_EN/PAR_TYP and the PARITY state per REQ-015/016.
REQ-027 SHALL, without the macro, omit PAR_EN, PAR_TYP, the PARITY state and the parity logic; frames are always 2+DATA_WIDTH cycles.

Structure
REQ-028 SHALL take the FSM state encoding (IDLE/START/DATA/PARITY/STOP) and the parity-type constants (EVEN=0, ODD=1) from shared package uart_pkg, which RX also uses.
REQ-029 SHALL instantiate one sub-module, uart_tx_serializer, holding the data register, bit counter and last-bit flag; FSM, parity and output mux stay in uart_tx.

Verification
REQ-030 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1; BUSY high for 11 cycles.
REQ-031 SHALL cover: P_DATA=0xA5, PAR_TYP=1 -> parity bit 1; P_DATA=0x00, PAR_TYP=1 -> parity 1; P_DATA=0xFF, PAR_TYP=0 -> parity 0.
REQ-032 SHALL cover: PAR_EN=0, P_DATA=0x3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1.
REQ-033 SHALL cover: DATA_VALID held high with 0x11 then 0x22 -> second START immediately after first STOP; BUSY never drops.
REQ-034 SHALL cover: DATA_VALID pulsed and P_DATA changed mid-frame -> current frame is unchanged and no extra frame is sent.
REQ-035 SHALL cover: RST=0 during DATA bit 4 -> TX_OUT=1 and BUSY=0 immediately; no frame resumes after release.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   uart_state_t  frame FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   PAR_EVEN/ODD  parity-type constants as seen on the PAR_TYP input
//   parity_bit()  turns the XOR of the data bits into the on-wire parity bit
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even parity transmits the XOR of the data bits; odd parity transmits its
  // inverse so that data plus parity always contains an odd number of ones.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer -- data shift register and bit counter for uart_tx.
//
// Ports:
//   CLK      bit clock
//   RST      asynchronous active-low reset (clears data and counter)
//   load     latch p_data and restart the bit counter
//   shift    move the next data bit into bit_out (LSB first)
//   advance  count one transmitted data bit
//   p_data   parallel word to serialise
//   bit_out  data bit to drive next
//   last_bit the bit currently on the line is the final data bit
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  bit_out,
  output logic                  last_bit
);

  // A one-bit word still needs a one-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (load) begin
        data_reg <= p_data;
      end else if (shift) begin
        data_reg <= data_reg >> 1;
      end

      // The counter tracks which data bit is on the line and returns to
      // zero as the last one leaves, ready for the next frame.
      if (load) begin
        cnt_reg <= '0;
      end else if (advance) begin
        cnt_reg <= last_bit ? '0 : cnt_reg + CNT_W'(1);
      end
    end
  end

  // bit_out is sampled by the FSM on the same edge that shifts, so bit 0 is
  // presented when entering DATA and bit k+1 while bit k is on the line.
  assign bit_out  = data_reg[0];
  assign last_bit = (cnt_reg == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter, one serial bit per CLK cycle.
//
// Frame: START(0), DATA_WIDTH data bits LSB first, optional PARITY, STOP(1).
// A new word is accepted in IDLE or in STOP, so frames can run back to back.
//
// Ports:
//   CLK         bit clock
//   RST         asynchronous active-low reset
//   P_DATA      parallel word, latched when accepted
//   DATA_VALID  request; ignored while a frame is in START/DATA/PARITY
//   PAR_EN      insert parity bit        (only with UART_TX_PARITY_EN)
//   PAR_TYP     0 = even, 1 = odd parity (only with UART_TX_PARITY_EN)
//   TX_OUT      registered serial line, idle high
//   BUSY        registered, high from START through STOP
//
// Build option: define UART_TX_PARITY_EN to compile in the parity feature.
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  uart_state_t state_reg, state_next;
  logic        tx_out_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        load, shift, advance;
  logic        ser_bit, last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .shift   (shift),
    .advance (advance),
    .p_data  (P_DATA),
    .bit_out (ser_bit),
    .last_bit(last_bit)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is resolved at acceptance so later changes on P_DATA/PAR_TYP
  // cannot affect the frame in flight.
  logic par_en_reg;
  logic par_bit_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (load) begin
      par_en_reg  <= PAR_EN;
      par_bit_reg <= parity_bit(^P_DATA, PAR_TYP);
    end
  end
`endif

  // Next state, then outputs decoded from the next state so that TX_OUT and
  // BUSY can be registered without lagging the FSM by a cycle.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    tx_next    = 1'b1;
    busy_next  = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (DATA_VALID) begin
          state_next = ST_START;
          load       = 1'b1;
        end
      end
      ST_START: state_next = ST_DATA;
      ST_DATA: begin
        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = par_en_reg ? ST_PARITY : ST_STOP;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: state_next = ST_STOP;
`endif
      ST_STOP: begin
        if (DATA_VALID) begin
          state_next = ST_START;
          load       = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_IDLE:   busy_next = 1'b0;
      ST_START:  tx_next   = 1'b0;
      ST_DATA:   tx_next   = ser_bit;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next   = par_bit_reg;
`endif
      default:   tx_next   = 1'b1;
    endcase
  end

  assign shift   = (state_next == ST_DATA);
  assign advance = (state_reg == ST_DATA);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      tx_out_reg <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tx_out_reg <= tx_next;
      busy_reg   <= busy_next;
    end
  end

  assign TX_OUT = tx_out_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed, scoreboard-based bench for uart_tx.
// Expected (TX_OUT, BUSY) pairs are queued when a request is driven and
// compared one per cycle on the falling edge. Parity cases exercise the
// parity bit only when UART_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx_out;
  logic       busy;

  always #5 CLK = ~CLK;

  uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
`ifdef UART_TX_PARITY_EN
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
`endif
    .TX_OUT    (tx_out),
    .BUSY      (busy)
  );

  typedef struct {
    logic tx;
    logic busy;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    sample_idx = 0;
  string cur_tag = "init";

  function automatic void push_exp(input logic tx, input logic bsy);
    exp_t e;
    e.tx   = tx;
    e.busy = bsy;
    sb_q.push_back(e);
  endfunction

  // Reference frame: start, LSB-first data, optional parity, stop.
  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
    push_exp(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(d[i], 1'b1);
    if (PARITY_BUILT && pen) push_exp((^d) ^ ptyp, 1'b1);
    push_exp(1'b1, 1'b1);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(1'b1, 1'b0);
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", name, got, exp);
    end
  endtask

  task automatic step_check();
    exp_t e;
    @(negedge CLK);
    e = sb_q.pop_front();
    check_bit($sformatf("%s tx[%0d]", cur_tag, sample_idx), tx_out, e.tx);
    check_bit($sformatf("%s busy[%0d]", cur_tag, sample_idx), busy, e.busy);
    sample_idx++;
  endtask

  task automatic drain();
    while (sb_q.size() > 0) step_check();
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic pen, input logic ptyp);
    cur_tag    = tag;
    sample_idx = 0;
    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = 1'b1;
    push_frame(p_data, par_en, par_typ);
    step_check();
    data_valid = 1'b0;
    drain();
    push_idle(2);
    drain();
    $display("frame %s data=%02h par_en=%b par_typ=%b checks=%0d failures=%0d",
             tag, d, pen, ptyp, checks, failures);
  endtask

  initial begin
    // Reset state
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    cur_tag = "reset";
    check_bit("reset tx", tx_out, 1'b1);
    check_bit("reset busy", busy, 1'b0);
    RST = 1'b1;
    sample_idx = 0;
    push_idle(2);
    drain();
    $display("reset released, line idle");

    // Single frames, with and without parity
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0);
    send_frame("a5_odd",  8'hA5, 1'b1, 1'b1);
    send_frame("00_odd",  8'h00, 1'b1, 1'b1);
    send_frame("ff_even", 8'hFF, 1'b1, 1'b0);
    send_frame("3c_nopar", 8'h3C, 1'b0, 1'b0);

    // Back-to-back: DATA_VALID held through the first frame
    cur_tag    = "b2b";
    sample_idx = 0;
    p_data     = 8'h11;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b0);
    step_check();
    p_data = 8'h22;
    repeat (9) step_check();
    step_check();
    data_valid = 1'b0;
    drain();
    push_idle(3);
    drain();
    $display("frame b2b data=11,22 checks=%0d failures=%0d", checks, failures);

    // Mid-frame request and input changes are ignored
    cur_tag    = "midpulse";
    sample_idx = 0;
    p_data     = 8'h5A;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'h5A, 1'b1, 1'b0);
    step_check();
    data_valid = 1'b0;
    repeat (2) step_check();
    data_valid = 1'b1;
    p_data     = 8'hFF;
    par_en     = 1'b0;
    par_typ    = 1'b1;
    step_check();
    data_valid = 1'b0;
    drain();
    push_idle(4);
    drain();
    $display("frame midpulse data=5a checks=%0d failures=%0d", checks, failures);

    // Reset during data bit 4 (bit 4 of 0xEF is 0, so the forced 1 is visible)
    cur_tag    = "rst_abort";
    sample_idx = 0;
    p_data     = 8'hEF;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    push_frame(8'hEF, 1'b0, 1'b0);
    step_check();
    data_valid = 1'b0;
    repeat (5) step_check();
    RST = 1'b0;
    #1;
    check_bit("rst_abort tx", tx_out, 1'b1);
    check_bit("rst_abort busy", busy, 1'b0);
    sb_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    cur_tag    = "post_rst";
    sample_idx = 0;
    push_idle(12);
    drain();
    $display("frame rst_abort data=ef checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
